systolic_array_ctrl: RTL and testbench
======================================

// Module: systolic_array_ctrl
// PURPOSE
//  Sequencer for the CNN systolic array. On start it fetches all filter weights and biases
//  from a parameter memory and writes them into the array through one-hot filter/bias strobes.
//  It then streams frame_len input vectors into the array and marks each result with out_valid.
//  Sits between the line-buffer/im2col stage and the systolic array.
// PARAMETERS
//  CHANNEL   1   input channels
//  FILTERS   4   output channels (array WIDTH)
//  F_WIDTH   2   kernel edge; HEIGHT = CHANNEL*F_WIDTH*F_WIDTH
//  I_D_SIZE  4   input element width
//  F_D_SIZE  4   weight width
//  B_D_SIZE  24  bias width (= parameter memory data width)
//  PIPE_LAT  HEIGHT+FILTERS+1  cycles from input acceptance to aligned array output
//  CNT_W     16  frame-length counter width
// PORTS
//  clk            in   1                   clock
//  rst_n          in   1                   async reset, active low
//  clk_en         in   1                   global clock enable; no state changes when 0
//  start          in   1                   begin load+run; honoured only in IDLE
//  frame_len      in   CNT_W               number of vectors to stream; sampled on start
//  busy           out  1                   high in every state except IDLE
//  done           out  1                   1-cycle pulse at DRAIN->IDLE
//  prm_rd         out  1                   parameter memory read request
//  prm_addr       out  $clog2(HEIGHT*FILTERS+FILTERS)  read address
//  prm_data       in   B_D_SIZE            read data
//  prm_vld        in   1                   read data valid
//  filter_o       out  F_D_SIZE            = prm_data[F_D_SIZE-1:0]
//  filter_we      out  [HEIGHT][FILTERS]   one-hot PE weight strobe
//  bias_o         out  B_D_SIZE            = prm_data
//  bias_we        out  FILTERS             one-hot bias strobe
//  in_valid/in_ready  in/out  1            input vector handshake
//  in_data        in   [HEIGHT][I_D_SIZE]  input vector
//  vec_o          out  [HEIGHT][I_D_SIZE]  to array vectorized_input
//  out_valid      out  1                   array vectorized_output is valid this cycle
// BEHAVIOUR
//  - All registers advance only when clk_en=1. Reset values: state=IDLE, all outputs 0.
//  - FSM: IDLE -start-> LOAD_W -> LOAD_B -> RUN -> DRAIN -> IDLE.
//  - LOAD_W: index k = r*FILTERS+c, with r 0..HEIGHT-1 and c 0..FILTERS-1 (c fastest).
//    - Exactly one read is outstanding at a time: prm_rd is high for one cycle with prm_addr=k,
//      then the controller waits for prm_vld.
//    - On prm_vld, filter_we[r][c]=1 (combinational, only that bit) and the next read is issued
//      on the following cycle.
//  - LOAD_B: addresses HEIGHT*FILTERS+c for c 0..FILTERS-1; bias_we[c]=1 on prm_vld.
//    Moves to RUN after the last bias.
//  - prm_vld outside an outstanding read is ignored; no strobe is generated.
//  - RUN: in_ready=1. On a beat (in_valid & in_ready):
//    - vec_o = in_data; otherwise vec_o = '0 (bubbles feed zeros).
//    - The beat counter increments. When the counter reaches frame_len, in_ready drops on the
//      next cycle and the FSM enters DRAIN.
//  - frame_len=0: RUN is skipped; LOAD_B goes straight to DRAIN.
//  - Valid shift register vsr[PIPE_LAT]: bit0 <= beat, shifting once per clk_en cycle.
//    out_valid = vsr[PIPE_LAT-1].
//  - DRAIN: wait until vsr is all zero, then pulse done for 1 cycle and return to IDLE.
//  - start while busy is ignored. start and the done cycle together: start is ignored.
//  - rst_n low mid-operation: state, counters and vsr clear immediately.
//    The array contents are not cleared.
//  - filter_we, bias_we and prm_rd are never asserted while clk_en=0.
// CONFIGURATION
//  SA_CTRL_SKIP_RELOAD_EN defined:
//    - Adds input reload (sampled on start). reload=0 after one completed load goes
//      IDLE->RUN directly; no prm_rd is issued.
//    - The first start after reset always loads.
//  Undefined: every start performs a full LOAD_W/LOAD_B; the reload port is absent.
// TESTING
//  1 Defaults. start with frame_len=3 and prm_vld 1 cycle after each prm_rd
//    -> 16 filter_we pulses at addresses 0..15 in row-major order.
//    -> Then 4 bias_we pulses at addresses 16..19 and bias_o = prm_data.
//  2 RUN with 3 back-to-back beats -> out_valid high for exactly 3 cycles, starting
//    PIPE_LAT(=9) cycles after the first beat. done pulses once; busy then returns to 0.
//  3 in_valid toggling 1,0,1,0,1 -> vec_o=0 on bubbles and out_valid follows the same
//    pattern delayed by 9.
//  4 clk_en low for 5 cycles during LOAD_W -> prm_addr, state and strobes frozen;
//    sequence completes with 20 strobes total.
//  5 rst_n asserted in the middle of RUN -> busy=0, out_valid=0, no done pulse. A new start
//    reloads from address 0.
//  6 frame_len=0 -> no in_ready and no out_valid; done follows the 20 load strobes.
//    With SA_CTRL_SKIP_RELOAD_EN and reload=0 on the second start -> zero prm_rd.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Load/run sequencer for the CNN systolic array: streams weights and biases in, then input vectors.
// Optional macro SA_CTRL_SKIP_RELOAD_EN adds a reload input that can skip reloading parameters.
module systolic_array_ctrl #(
  parameter int CHANNEL  = 1,
  parameter int FILTERS  = 4,
  parameter int F_WIDTH  = 2,
  parameter int I_D_SIZE = 4,
  parameter int F_D_SIZE = 4,
  parameter int B_D_SIZE = 24,
  parameter int HEIGHT   = CHANNEL * F_WIDTH * F_WIDTH,
  parameter int PIPE_LAT = HEIGHT + FILTERS + 1,
  parameter int CNT_W    = 16,
  parameter int AW       = $clog2(HEIGHT * FILTERS + FILTERS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clk_en,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     frame_len,
`ifdef SA_CTRL_SKIP_RELOAD_EN
  input  logic                                 reload,
`endif
  output logic                                 busy,
  output logic                                 done,
  output logic                                 prm_rd,
  output logic [AW-1:0]                        prm_addr,
  input  logic [B_D_SIZE-1:0]                  prm_data,
  input  logic                                 prm_vld,
  output logic [F_D_SIZE-1:0]                  filter_o,
  output logic [HEIGHT-1:0][FILTERS-1:0]       filter_we,
  output logic [B_D_SIZE-1:0]                  bias_o,
  output logic [FILTERS-1:0]                   bias_we,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [HEIGHT-1:0][I_D_SIZE-1:0]      in_data,
  output logic [HEIGHT-1:0][I_D_SIZE-1:0]      vec_o,
  output logic                                 out_valid
);
  localparam int NW = HEIGHT * FILTERS;
  localparam logic [AW-1:0] LAST_W  = AW'(NW - 1);
  localparam logic [AW-1:0] FIRST_B = AW'(NW);
  localparam logic [AW-1:0] LAST_B  = AW'(NW + FILTERS - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_B, RUN, DRAIN} state_t;

  state_t               state;
  logic                 prm_rd_q;
  logic                 pend;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [CNT_W-1:0]     frame_len_q;
  logic [PIPE_LAT-1:0]  vsr;
  logic                 beat;
  logic                 accept;
  logic [AW-1:0]        bias_idx;
`ifdef SA_CTRL_SKIP_RELOAD_EN
  logic                 loaded;
`endif

  // A read counts as outstanding only from the cycle after prm_rd.
  assign beat      = clk_en & in_valid & in_ready;
  assign accept    = clk_en & pend & prm_vld;
  assign prm_rd    = prm_rd_q & clk_en;
  assign busy      = (state != IDLE);
  assign filter_o  = prm_data[F_D_SIZE-1:0];
  assign bias_o    = prm_data;
  assign vec_o     = beat ? in_data : '0;
  assign out_valid = vsr[PIPE_LAT-1];
  assign bias_idx  = prm_addr - FIRST_B;
  assign cnt_nxt   = cnt + CNT_W'(1);

  always_comb begin
    filter_we = '0;
    bias_we   = '0;
    if (accept && state == LOAD_W) filter_we = NW'(1) << prm_addr;
    if (accept && state == LOAD_B) bias_we = FILTERS'(1) << bias_idx;
  end

  always_ff @(posedge clk) begin
    if (clk_en && state == IDLE && start) frame_len_q <= frame_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prm_rd_q <= 1'b0;
      pend     <= 1'b0;
      prm_addr <= '0;
      cnt      <= '0;
      vsr      <= '0;
      in_ready <= 1'b0;
      done     <= 1'b0;
`ifdef SA_CTRL_SKIP_RELOAD_EN
      loaded   <= 1'b0;
`endif
    end else if (clk_en) begin
      vsr  <= {vsr[PIPE_LAT-2:0], beat};
      done <= 1'b0;
      if (prm_rd_q) begin
        prm_rd_q <= 1'b0;
        pend     <= 1'b1;
      end
      if (accept) pend <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          cnt <= '0;
`ifdef SA_CTRL_SKIP_RELOAD_EN
          if (loaded && !reload) begin
            if (frame_len == '0) state <= DRAIN;
            else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end else begin
            state    <= LOAD_W;
            prm_rd_q <= 1'b1;
            prm_addr <= '0;
          end
`else
          state    <= LOAD_W;
          prm_rd_q <= 1'b1;
          prm_addr <= '0;
`endif
        end
        LOAD_W: if (accept) begin
          prm_addr <= prm_addr + AW'(1);
          prm_rd_q <= 1'b1;
          if (prm_addr == LAST_W) state <= LOAD_B;
        end
        LOAD_B: if (accept) begin
          if (prm_addr == LAST_B) begin
`ifdef SA_CTRL_SKIP_RELOAD_EN
            loaded <= 1'b1;
`endif
            if (frame_len_q == '0) state <= DRAIN;
            else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end else begin
            prm_addr <= prm_addr + AW'(1);
            prm_rd_q <= 1'b1;
          end
        end
        RUN: if (beat) begin
          cnt <= cnt_nxt;
          if (cnt_nxt == frame_len_q) begin
            in_ready <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: if (vsr == '0) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Randomized bench for systolic_array_ctrl: a transaction-level model tracks load order,
// beat counts and output timing, and every cycle is compared against it.
module tb_systolic_array_ctrl;
  localparam int HEIGHT = 4;
  localparam int FILTERS = 4;
  localparam int NP = HEIGHT * FILTERS + FILTERS;
  localparam int LAT = HEIGHT + FILTERS + 1;

  logic clk, rst_n, clk_en, start, busy, done, prm_rd, prm_vld;
  logic [15:0] frame_len;
  logic reload;
  logic [4:0] prm_addr;
  logic [23:0] prm_data, bias_o;
  logic [3:0] filter_o, bias_we;
  logic [3:0][3:0] filter_we, in_data, vec_o;
  logic in_valid, in_ready, out_valid;

  systolic_array_ctrl dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .frame_len(frame_len),
`ifdef SA_CTRL_SKIP_RELOAD_EN
    .reload(reload),
`endif
    .busy(busy), .done(done), .prm_rd(prm_rd), .prm_addr(prm_addr), .prm_data(prm_data),
    .prm_vld(prm_vld), .filter_o(filter_o), .filter_we(filter_we), .bias_o(bias_o),
    .bias_we(bias_we), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .vec_o(vec_o), .out_valid(out_valid)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [23:0] mem [NP];
  int rsp_dly_max = 0;

  // Parameter memory: one read outstanding, answers after a random delay, holds vld until taken.
  initial begin
    bit pend_r = 0;
    int dly = 0;
    int raddr = 0;
    prm_vld = 0;
    prm_data = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend_r = 0;
      else begin
        if (pend_r && prm_vld && clk_en) pend_r = 0;
        if (prm_rd) begin
          pend_r = 1;
          raddr = int'(prm_addr);
          dly = $urandom_range(0, rsp_dly_max);
        end
      end
      @(posedge clk);
      #1;
      if (pend_r) begin
        if (dly == 0) begin
          prm_vld = 1;
          prm_data = (raddr < NP) ? mem[raddr] : 24'h0;
        end else begin
          dly--;
          prm_vld = 0;
          prm_data = 24'($urandom);
        end
      end else begin
        prm_vld = ($urandom_range(0, 3) == 0);
        prm_data = 24'($urandom);
      end
    end
  end

  // Reference model: phase 0 idle, 1 loading, 2 streaming, 3 draining.
  int m_phase = 0, m_k = 0, m_beats = 0, m_flen = 0, E = 0, cyc = 0;
  bit m_rd_due = 0, m_outst = 0, m_done_exp = 0, m_loaded = 0;
  int beat_q[$];
  int n_fwe = 0, n_bwe = 0, n_rd = 0, n_ov = 0, n_done = 0, n_rdy = 0;
  int first_beat = -1, first_ov = -1;
  bit exp_ready, exp_beat, exp_ov, exp_rd, exp_strobe, drain_empty, done_next;
  logic [15:0] efw;
  logic [3:0] ebw;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_rd_due = 0; m_outst = 0; m_done_exp = 0; m_loaded = 0;
      beat_q.delete();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_prm_rd", prm_rd, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_prm_addr", prm_addr, 0);
      check("rst_filter_we", filter_we, 0);
      check("rst_bias_we", bias_we, 0);
    end else begin
      cyc++;
      exp_ready = (m_phase == 2);
      exp_beat = clk_en && in_valid && exp_ready;
      exp_ov = 0;
      foreach (beat_q[i]) if (beat_q[i] == E - LAT) exp_ov = 1;
      exp_rd = clk_en && m_rd_due;
      exp_strobe = clk_en && m_outst && prm_vld && (m_phase == 1);
      efw = (exp_strobe && m_k < 16) ? (16'(1) << m_k) : 16'h0;
      ebw = (exp_strobe && m_k >= 16) ? (4'(1) << (m_k - 16)) : 4'h0;
      check("busy", busy, m_phase != 0);
      check("in_ready", in_ready, exp_ready);
      check("prm_rd", prm_rd, exp_rd);
      if (exp_rd) check("prm_addr", prm_addr, m_k);
      check("filter_we", filter_we, efw);
      check("bias_we", bias_we, ebw);
      if (exp_strobe) begin
        if (m_k < 16) check("filter_o", filter_o, mem[m_k][3:0]);
        else check("bias_o", bias_o, mem[m_k]);
      end
      check("vec_o", vec_o, exp_beat ? in_data : 16'h0);
      check("out_valid", out_valid, exp_ov);
      check("done", done, m_done_exp);
      if (clk_en && out_valid) n_ov++;
      if (clk_en && done) n_done++;
      if (clk_en && in_ready) n_rdy++;
      if (prm_rd) n_rd++;
      if (|filter_we) n_fwe++;
      if (|bias_we) n_bwe++;
      if (exp_beat && first_beat < 0) first_beat = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (clk_en) begin
        drain_empty = 1;
        foreach (beat_q[i]) if (beat_q[i] >= E - LAT) drain_empty = 0;
        if (exp_beat) beat_q.push_back(E);
        while (beat_q.size() > 0 && beat_q[0] < E - 2 * LAT) void'(beat_q.pop_front());
        done_next = 0;
        case (m_phase)
          0: if (start && !m_done_exp) begin
            m_flen = int'(frame_len);
            m_beats = 0;
`ifdef SA_CTRL_SKIP_RELOAD_EN
            if (m_loaded && !reload) m_phase = (frame_len == 0) ? 3 : 2;
            else begin m_phase = 1; m_k = 0; m_rd_due = 1; end
`else
            m_phase = 1; m_k = 0; m_rd_due = 1;
`endif
          end
          1: begin
            if (exp_rd) begin
              m_rd_due = 0;
              m_outst = 1;
            end else if (exp_strobe) begin
              m_outst = 0;
              m_k++;
              if (m_k == NP) begin
                m_loaded = 1;
                m_phase = (m_flen == 0) ? 3 : 2;
              end else m_rd_due = 1;
            end
          end
          2: if (exp_beat) begin
            m_beats++;
            if (m_beats == m_flen) m_phase = 3;
          end
          3: if (drain_empty) begin
            m_phase = 0;
            done_next = 1;
          end
          default: m_phase = 0;
        endcase
        m_done_exp = done_next;
        E++;
      end
    end
  end

  // vmode: 0 always valid, 1 alternating 1,0,1.., 2 random. enmode: 0 on, 1 freeze 5 in load, 2 random.
  task automatic run_op(input int flen, input int vmode, input int enmode, input bit rl,
                        input bit expload, input string tag);
    int f0, b0, r0, o0, d0, y0, frz;
    bit alt, seen;
    f0 = n_fwe; b0 = n_bwe; r0 = n_rd; o0 = n_ov; d0 = n_done; y0 = n_rdy;
    first_beat = -1; first_ov = -1;
    @(posedge clk); #1;
    clk_en = 1; start = 1; frame_len = 16'(flen); reload = rl;
    alt = 1; frz = 0; seen = 0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(posedge clk); #1;
      start = m_done_exp || (m_phase != 0 && $urandom_range(0, 7) == 0);
      frame_len = 16'($urandom);
      reload = 1'($urandom);
      in_data = 16'($urandom);
      if (m_phase == 2) begin
        in_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? alt : 1'($urandom);
        alt = ~alt;
      end else in_valid = 1'($urandom);
      case (enmode)
        1: begin
          if (frz == 0 && m_phase == 1 && m_k == 5) frz = 1;
          if (frz >= 1 && frz <= 5) begin clk_en = 0; frz++; end
          else clk_en = 1;
        end
        2: clk_en = ($urandom_range(0, 3) != 0);
        default: clk_en = 1;
      endcase
      @(negedge clk);
      if (done) seen = 1;
    end
    @(posedge clk); #1;
    start = 0; clk_en = 1; in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    if (!seen) check({tag, "_timeout"}, 0, 1);
    check({tag, "_filter_strobes"}, n_fwe - f0, expload ? 16 : 0);
    check({tag, "_bias_strobes"}, n_bwe - b0, expload ? 4 : 0);
    check({tag, "_reads"}, n_rd - r0, expload ? 20 : 0);
    check({tag, "_out_valid_cnt"}, n_ov - o0, flen);
    check({tag, "_done_cnt"}, n_done - d0, 1);
    if (flen == 0) check({tag, "_in_ready_cnt"}, n_rdy - y0, 0);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int t, d0;
    foreach (mem[i]) mem[i] = 24'($urandom);
    rst_n = 0; clk_en = 1; start = 0; frame_len = 0; reload = 1; in_valid = 0; in_data = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    run_op(3, 0, 0, 1, 1, "basic");
    check("latency", first_ov - first_beat, LAT);
    rsp_dly_max = 2;
    run_op(5, 1, 0, 1, 1, "bubbles");
    run_op(6, 2, 1, 1, 1, "freeze");
    run_op(7, 2, 2, 1, 1, "rand_en");

    // Asynchronous reset in the middle of streaming.
    @(posedge clk); #1;
    frame_len = 8; start = 1; clk_en = 1; in_valid = 1; reload = 1;
    @(posedge clk); #1;
    start = 0;
    t = 0;
    while (!(m_phase == 2 && m_beats >= 3) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) check("run_reach_timeout", 0, 1);
    #2 rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    d0 = n_done;
    repeat (3) @(posedge clk);
    #1 rst_n = 1; in_valid = 0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done", n_done - d0, 0);

    run_op(3, 2, 0, 1, 1, "after_rst");
    run_op(0, 2, 0, 1, 1, "zero_len");
`ifdef SA_CTRL_SKIP_RELOAD_EN
    run_op(4, 2, 0, 0, 0, "skip");
    run_op(0, 2, 2, 0, 0, "skip_zero");
    run_op(2, 2, 0, 1, 1, "forced_reload");
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
